transient_shaper_v2: RTL and testbench
======================================

TRANSIENT_SHAPER_V2 -- requirements
Module: transient_shaper_v2

Interface
REQ-001 SHALL have parameter IN_W, default 6: input sample width (unsigned).
REQ-002 SHALL have parameter OUT_W, default 8: output sample width (unsigned).
REQ-003 SHALL have parameter AMT_W, default 2: width of the attack and sustain gain codes.
REQ-004 SHALL have parameter FRAC, default 4: fractional bits in the envelope registers.
REQ-005 SHALL have parameters FAST_SH, default 1, and SLOW_SH, default 4: envelope smoothing shifts, with FAST_SH < SLOW_SH.
REQ-006 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port ena, input, 1: global enable.
REQ-009 SHALL have port in_valid, input, 1: audio_in holds a new sample this cycle.
REQ-010 SHALL have port audio_in, input, IN_W: unsigned sample.
REQ-011 SHALL have port attack_amt, input, AMT_W: transient gain code, 0 to 2^AMT_W-1.
REQ-012 SHALL have port sustain_amt, input, AMT_W: sustain gain code.
REQ-013 SHALL have port bypass, input, 1: pass the sample through unshaped.
REQ-014 SHALL have port audio_out, output, OUT_W: shaped, saturated sample.
REQ-015 SHALL have port out_valid, output, 1: audio_out and sat are valid this cycle.
REQ-016 SHALL have port sat, output, 1: audio_out was clamped for this sample.

Function
REQ-017 SHALL accept a sample only on a cycle with ena=1 and in_valid=1; no backpressure, so every accepted sample produces exactly one output.
REQ-018 SHALL use a two-stage pipeline: on accept edge N, stage 1 registers the sample, bypass, attack_amt, sustain_amt and the updated envelopes; on edge N+1, stage 2 registers audio_out and sat and sets out_valid=1 for one cycle.
REQ-019 SHALL keep two envelopes env_f and env_s, each IN_W+FRAC bits unsigned, with x = audio_in << FRAC.
REQ-020 SHALL update each envelope only on accept, using step = (x - env) >>> SH (signed, arithmetic, with SH = FAST_SH or SLOW_SH).
REQ-021 SHALL force step = +1 whenever x > env and the computed step is 0, so that each envelope reaches x exactly; env_next = env + step.
REQ-022 SHALL, in stage 2, take integer parts ef = env_f >> FRAC and es = env_s >> FRAC from the stage-1 registers.
REQ-023 SHALL compute attack_boost = (ef - es) * attack_amt when ef > es, else 0.
REQ-024 SHALL compute sustain_boost = (es * sustain_amt) >> 1, truncating.
REQ-025 SHALL form sum = sample + attack_boost + sustain_boost at full width (no intermediate overflow), then set audio_out = min(sum, 2^OUT_W-1) and sat = (sum > 2^OUT_W-1).
REQ-026 SHALL, when the registered bypass=1, output audio_out = zero-extended sample with sat=0, still with two-cycle latency; envelopes keep tracking during bypass.
REQ-027 SHALL sample the gain codes and bypass per sample at accept; changes between accepts have no effect on in-flight samples.
REQ-028 SHALL, while ena=0, hold the envelopes, stage-1 and stage-2 data and audio_out, and register out_valid=0; in-flight samples resume when ena returns to 1.
REQ-029 SHALL ignore in_valid=1 while ena=0: no sample is accepted and the envelopes are unchanged.

Reset
REQ-030 SHALL, while rst_n=0, immediately clear env_f, env_s, all pipeline registers, audio_out, out_valid and sat to 0.
REQ-031 SHALL discard in-flight samples on a mid-operation reset; the first sample accepted after reset release appears two edges later.

Verification
REQ-032 SHALL cover reset: assert rst_n=0 mid-stream -> audio_out=0, out_valid=0, sat=0 immediately, with no stale output after release.
REQ-033 SHALL cover the step response (defaults): in 0 -> 40, attack=3, sustain=0 -> first output 94 (ef=20, es=2), two edges after accept.
REQ-034 SHALL cover steady state: constant in=63, attack=3, sustain=3 for 200 samples -> ef=es=63, audio_out=157, sat=0.
REQ-035 SHALL cover saturation with OUT_W=7: in 0 -> 63, attack=3 -> sum 147, audio_out=127, sat=1.
REQ-036 SHALL cover bypass: in=50, bypass=1, attack=sustain=3 -> audio_out=50, sat=0; after bypass drops, envelopes reflect the samples seen during bypass.
REQ-037 SHALL cover the enable hold: drop ena for 5 cycles with a sample in flight -> out_valid=0 and outputs held; the sample emerges after ena=1 with the unchanged value; zero input stays at 0.

Source files
------------

// File: rtl/transient_shaper_v2.sv
// Transient shaper: fast/slow envelope followers drive an attack boost
// (fast minus slow) and a sustain boost (slow), added to the sample and clamped.
module transient_shaper_v2 #(
    parameter int IN_W    = 6,
    parameter int OUT_W   = 8,
    parameter int AMT_W   = 2,
    parameter int FRAC    = 4,
    parameter int FAST_SH = 1,
    parameter int SLOW_SH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  audio_in,
    input  logic [AMT_W-1:0] attack_amt,
    input  logic [AMT_W-1:0] sustain_amt,
    input  logic             bypass,
    output logic [OUT_W-1:0] audio_out,
    output logic             out_valid,
    output logic             sat
);
    localparam int EW     = IN_W + FRAC;
    localparam int GROW_W = IN_W + AMT_W + 2;
    localparam int SUM_W  = (GROW_W > OUT_W + 1) ? GROW_W : OUT_W + 1;
    localparam logic [SUM_W-1:0] OUT_MAX = SUM_W'((64'd1 << OUT_W) - 64'd1);

    logic            accept;
    logic [EW-1:0]   x;

    assign accept = ena & in_valid;
    assign x      = {audio_in, {FRAC{1'b0}}};

    // One smoothing step toward x; a zero step while still below x is bumped
    // to +1 so the envelope settles exactly on x instead of stalling short.
    function automatic logic [EW-1:0] env_step(input logic [EW-1:0] env,
                                               input logic [EW-1:0] target,
                                               input int sh);
        logic signed [EW:0] diff;
        logic signed [EW:0] step;
        diff = $signed({1'b0, target}) - $signed({1'b0, env});
        step = diff >>> sh;
        if ((target > env) && (step == '0))
            step = (EW+1)'(1);
        return env + step[EW-1:0];
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : env_gen
        localparam int SH = (gi == 0) ? FAST_SH : SLOW_SH;
        logic [EW-1:0] env_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                env_reg <= '0;
            else if (accept)
                env_reg <= env_step(env_reg, x, SH);
        end
    end

    logic             s1_valid;
    logic [IN_W-1:0]  s1_sample;
    logic             s1_bypass;
    logic [AMT_W-1:0] s1_att;
    logic [AMT_W-1:0] s1_sus;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_bypass <= 1'b0;
            s1_att    <= '0;
            s1_sus    <= '0;
        end else if (ena) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sample <= audio_in;
                s1_bypass <= bypass;
                s1_att    <= attack_amt;
                s1_sus    <= sustain_amt;
            end
        end
    end

    // Envelope registers double as the stage-1 envelope snapshot: they only
    // move on accept, and stage 2 reads them one ena-edge after that accept.
    logic [IN_W-1:0]  ef;
    logic [IN_W-1:0]  es;
    logic [SUM_W-1:0] attack_boost;
    logic [SUM_W-1:0] sustain_boost;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sample_ext;
    logic [OUT_W-1:0] out_next;
    logic             sat_next;

    assign ef = env_gen[0].env_reg[EW-1:FRAC];
    assign es = env_gen[1].env_reg[EW-1:FRAC];

    always_comb begin
        attack_boost = '0;
        if (ef > es)
            attack_boost = SUM_W'(ef - es) * SUM_W'(s1_att);
        sustain_boost = (SUM_W'(es) * SUM_W'(s1_sus)) >> 1;
        sample_ext    = SUM_W'(s1_sample);
        sum           = sample_ext + attack_boost + sustain_boost;
        sat_next      = 1'b0;
        out_next      = sample_ext[OUT_W-1:0];
        if (!s1_bypass) begin
            sat_next = (sum > OUT_MAX);
            out_next = sat_next ? {OUT_W{1'b1}} : sum[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_out <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
        end else if (ena) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                audio_out <= out_next;
                sat       <= sat_next;
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_transient_shaper_v2.sv
// Bench for transient_shaper_v2: default and OUT_W=7 instances share stimulus,
// checked against a sample-level arithmetic model plus fixed vectors.
module tb_transient_shaper_v2;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       in_valid = 1'b0;
    logic [5:0] audio_in = '0;
    logic [1:0] attack_amt = '0;
    logic [1:0] sustain_amt = '0;
    logic       bypass = 1'b0;
    logic [7:0] out8;
    logic       valid8, sat8;
    logic [6:0] out7;
    logic       valid7, sat7;

    always #5 clk = ~clk;

    transient_shaper_v2 dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid),
        .audio_in(audio_in), .attack_amt(attack_amt), .sustain_amt(sustain_amt),
        .bypass(bypass), .audio_out(out8), .out_valid(valid8), .sat(sat8)
    );

    transient_shaper_v2 #(.OUT_W(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid),
        .audio_in(audio_in), .attack_amt(attack_amt), .sustain_amt(sustain_amt),
        .bypass(bypass), .audio_out(out7), .out_valid(valid7), .sat(sat7)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: envelopes in x16 fixed point, sample-level arithmetic.
    int m_envf, m_envs;
    bit m_pend;
    int p_out8, p_sat8, p_out7, p_sat7;
    bit e_valid;
    int e_out8, e_sat8, e_out7, e_sat7;

    function automatic int floor_div(input int a, input int d);
        return (a >= 0) ? a / d : -((-a + d - 1) / d);
    endfunction

    function automatic int follow(input int env, input int xs, input int sh);
        int st;
        st = floor_div(xs - env, 1 << sh);
        if (xs > env && st == 0) st = 1;
        return env + st;
    endfunction

    task automatic model_reset();
        m_envf = 0; m_envs = 0; m_pend = 0;
        e_valid = 0; e_out8 = 0; e_sat8 = 0; e_out7 = 0; e_sat7 = 0;
    endtask

    task automatic model_accept(input int s, input int a, input int su, input int b);
        int ef, es, total;
        m_envf = follow(m_envf, s * 16, 1);
        m_envs = follow(m_envs, s * 16, 4);
        ef = m_envf / 16;
        es = m_envs / 16;
        total = s + ((ef > es) ? (ef - es) * a : 0) + (es * su) / 2;
        if (b != 0) begin
            p_out8 = s; p_sat8 = 0; p_out7 = s; p_sat7 = 0;
        end else begin
            p_out8 = (total > 255) ? 255 : total; p_sat8 = (total > 255) ? 1 : 0;
            p_out7 = (total > 127) ? 127 : total; p_sat7 = (total > 127) ? 1 : 0;
        end
    endtask

    task automatic tick(input bit e, input bit v, input int s, input int a,
                        input int su, input bit b);
        ena = e; in_valid = v; audio_in = 6'(s);
        attack_amt = 2'(a); sustain_amt = 2'(su); bypass = b;
        @(posedge clk);
        if (e) begin
            e_valid = m_pend;
            if (m_pend) begin
                e_out8 = p_out8; e_sat8 = p_sat8; e_out7 = p_out7; e_sat7 = p_sat7;
            end
            m_pend = v;
            if (v) model_accept(s, a, su, int'(b));
        end else begin
            e_valid = 0;
        end
        #1;
        chk("model_valid8", int'(valid8), int'(e_valid));
        chk("model_out8",   int'(out8),   e_out8);
        chk("model_sat8",   int'(sat8),   e_sat8);
        chk("model_valid7", int'(valid7), int'(e_valid));
        chk("model_out7",   int'(out7),   e_out7);
        chk("model_sat7",   int'(sat7),   e_sat7);
    endtask

    task automatic do_reset();
        ena = 0; in_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_out8",   int'(out8),   0);
        chk("rst_valid8", int'(valid8), 0);
        chk("rst_sat8",   int'(sat8),   0);
        chk("rst_out7",   int'(out7),   0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        int in_s, att, sus, byp;
        int out8, sat8, out7, sat7;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{40, 3, 0, 0,  94, 0,  94, 0};
        vecs[1] = '{63, 3, 0, 0, 147, 0, 127, 1};
        vecs[2] = '{63, 3, 3, 0, 151, 0, 127, 1};
        vecs[3] = '{50, 3, 3, 1,  50, 0,  50, 0};
        vecs[4] = '{ 0, 3, 3, 0,   0, 0,   0, 0};
        vecs[5] = '{10, 1, 2, 0,  15, 0,  15, 0};
        vecs[6] = '{63, 0, 3, 0,  67, 0,  67, 0};

        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single sample from a cleared state, output two edges after accept.
        foreach (vecs[i]) begin
            do_reset();
            tick(1, 1, vecs[i].in_s, vecs[i].att, vecs[i].sus, vecs[i].byp);
            chk("vec_early_valid", int'(valid8), 0);
            tick(1, 0, 0, 0, 0, 0);
            chk("vec_valid", int'(valid8), 1);
            chk("vec_out8",  int'(out8), vecs[i].out8);
            chk("vec_sat8",  int'(sat8), vecs[i].sat8);
            chk("vec_out7",  int'(out7), vecs[i].out7);
            chk("vec_sat7",  int'(sat7), vecs[i].sat7);
        end

        // Steady state, then a reset with a sample in flight.
        do_reset();
        for (int i = 0; i < 200; i++) tick(1, 1, 63, 3, 3, 0);
        chk("steady_out8", int'(out8), 157);
        chk("steady_sat8", int'(sat8), 0);
        chk("steady_out7", int'(out7), 127);
        chk("steady_sat7", int'(sat7), 1);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            chk("post_rst_valid", int'(valid8), 0);
            chk("post_rst_out",   int'(out8), 0);
        end

        // Envelopes keep tracking while bypassed.
        do_reset();
        for (int i = 0; i < 100; i++) tick(1, 1, 50, 3, 3, 1);
        chk("bypass_out", int'(out8), 50);
        chk("bypass_sat", int'(sat8), 0);
        tick(1, 1, 50, 3, 3, 0);
        tick(1, 0, 0, 0, 0, 0);
        chk("after_bypass_out", int'(out8), 125);

        // Enable hold with a sample in flight; ignored inputs while ena=0.
        do_reset();
        tick(1, 1, 10, 1, 2, 0);
        tick(1, 1, 40, 3, 0, 0);
        chk("hold_pre_out", int'(out8), 15);
        for (int i = 0; i < 5; i++) begin
            tick(0, 1, $urandom_range(63), $urandom_range(3), $urandom_range(3), 0);
            chk("hold_valid", int'(valid8), 0);
            chk("hold_out",   int'(out8), 15);
        end
        tick(1, 0, 0, 0, 0, 0);
        chk("resume_valid", int'(valid8), 1);
        chk("resume_out",   int'(out8), 97);

        // Zero input stays at zero.
        do_reset();
        for (int i = 0; i < 6; i++) tick(1, 1, 0, 3, 3, 0);
        chk("zero_out", int'(out8), 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++)
            tick(($urandom_range(7) != 0), ($urandom_range(3) != 0),
                 $urandom_range(63), $urandom_range(3), $urandom_range(3),
                 ($urandom_range(7) == 0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
